// File: rtl/iv_power_multiplier.sv
// iv_power_multiplier: multiplies a fixed-point current and voltage sample into
// a fixed-point power word using a W-cycle unsigned shift-add on magnitudes.
// Optional build macro: POWER_SAT_EN (saturate RESULT_P on overflow instead of wrapping).
module iv_power_multiplier #(
  parameter int unsigned W    = 32,
  parameter int unsigned FRAC = 26
) (
  input  logic         CLK,
  input  logic         RST_PW,
  input  logic         ACK_I,
  input  logic [W-1:0] RESULT_I,
  input  logic         ACK_V,
  input  logic [W-1:0] RESULT_V,
  output logic         ACK_P,
  output logic         O_F,
  output logic [W-1:0] RESULT_P
);

  localparam int unsigned W2 = 2 * W;
  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [W-1:0]  ONE_W   = W'(1);
  localparam logic [W2-1:0] MIN_MAG = W2'(1) << (W - 1);
`ifdef POWER_SAT_EN
  localparam logic [W-1:0]  MAX_P   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MIN_P   = {1'b1, {(W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, WAIT, MULT, DONE} state_t;

  state_t         state_q, state_d;
  logic           armed_q, armed_d;
  logic           ack_i_q, ack_i_d;
  logic           ack_v_q, ack_v_d;
  logic [W-1:0]   op_i_q, op_i_d;
  logic [W-1:0]   op_v_q, op_v_d;
  logic           wait_i_q, wait_i_d;
  logic           pend_i_q, pend_i_d;
  logic           pend_v_q, pend_v_d;
  logic [W-1:0]   pend_i_val_q, pend_i_val_d;
  logic [W-1:0]   pend_v_val_q, pend_v_val_d;
  logic [W2-1:0]  mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [W2-1:0]  acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d;
  logic           rise_q, rise_d;
  logic           ack_p_q, ack_p_d;
  logic           of_q, of_d;
  logic [W-1:0]   res_q, res_d;

  logic           go_mult_c;
  logic [W-1:0]   a_sel_c, b_sel_c;

  // Two's-complement magnitude; the most negative value maps to 2^(W-1) unsigned.
  function automatic logic [W-1:0] mag_of(input logic [W-1:0] x);
    return x[W-1] ? ((~x) + ONE_W) : x;
  endfunction

  // Rising-edge events; suppressed for the first cycle after reset so a level
  // already high at release is absorbed into the edge-detect registers.
  logic ev_i_c, ev_v_c, busy_c, in_i_c, in_v_c;
  logic [W-1:0] val_i_c, val_v_c;
  assign ev_i_c  = armed_q & ACK_I & ~ack_i_q;
  assign ev_v_c  = armed_q & ACK_V & ~ack_v_q;
  // While busy, events go to the pending slots; afterwards pending slots act as events.
  assign busy_c  = (state_q == MULT) || (state_q == DONE) || rise_q;
  assign in_i_c  = ~busy_c & (ev_i_c | pend_i_q);
  assign in_v_c  = ~busy_c & (ev_v_c | pend_v_q);
  assign val_i_c = ev_i_c ? RESULT_I : pend_i_val_q;
  assign val_v_c = ev_v_c ? RESULT_V : pend_v_val_q;

  // Truncate the magnitude product, classify overflow and apply the sign.
  logic [W2-1:0] mag_sh_c;
  logic [W-1:0]  wrap_c, res_fin_c;
  logic          of_c;
  assign mag_sh_c = acc_q >> FRAC;
  assign of_c     = (|mag_sh_c[W2-1:W-1]) && !((mag_sh_c == MIN_MAG) && neg_q);
  assign wrap_c   = neg_q ? ((~mag_sh_c[W-1:0]) + ONE_W) : mag_sh_c[W-1:0];
`ifdef POWER_SAT_EN
  assign res_fin_c = of_c ? (neg_q ? MIN_P : MAX_P) : wrap_c;
`else
  assign res_fin_c = wrap_c;
`endif

  // Next-state and datapath update for capture, shift-add and result stages.
  always_comb begin
    state_d      = state_q;
    armed_d      = 1'b1;
    ack_i_d      = ACK_I;
    ack_v_d      = ACK_V;
    op_i_d       = op_i_q;
    op_v_d       = op_v_q;
    wait_i_d     = wait_i_q;
    pend_i_d     = pend_i_q;
    pend_v_d     = pend_v_q;
    pend_i_val_d = pend_i_val_q;
    pend_v_val_d = pend_v_val_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    neg_d        = neg_q;
    rise_d       = 1'b0;
    ack_p_d      = ack_p_q | rise_q;
    of_d         = of_q;
    res_d        = res_q;
    go_mult_c    = 1'b0;
    a_sel_c      = op_i_q;
    b_sel_c      = op_v_q;

    if (busy_c) begin
      if (ev_i_c) begin
        pend_i_d     = 1'b1;
        pend_i_val_d = RESULT_I;
      end
      if (ev_v_c) begin
        pend_v_d     = 1'b1;
        pend_v_val_d = RESULT_V;
      end
    end else begin
      pend_i_d = 1'b0;
      pend_v_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (in_i_c && in_v_c) begin
          go_mult_c = 1'b1;
          a_sel_c   = val_i_c;
          b_sel_c   = val_v_c;
        end else if (in_i_c) begin
          op_i_d   = val_i_c;
          wait_i_d = 1'b1;
          state_d  = WAIT;
        end else if (in_v_c) begin
          op_v_d   = val_v_c;
          wait_i_d = 1'b0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (wait_i_q) begin
          if (in_v_c) begin
            go_mult_c = 1'b1;
            a_sel_c   = in_i_c ? val_i_c : op_i_q;
            b_sel_c   = val_v_c;
          end else if (in_i_c) begin
            op_i_d = val_i_c;
          end
        end else begin
          if (in_i_c) begin
            go_mult_c = 1'b1;
            a_sel_c   = val_i_c;
            b_sel_c   = in_v_c ? val_v_c : op_v_q;
          end else if (in_v_c) begin
            op_v_d = val_v_c;
          end
        end
      end
      MULT: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        res_d    = res_fin_c;
        of_d     = of_c;
        rise_d   = 1'b1;
        wait_i_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (go_mult_c) begin
      state_d  = MULT;
      mcand_d  = {{W{1'b0}}, mag_of(a_sel_c)};
      mplier_d = mag_of(b_sel_c);
      acc_d    = '0;
      cnt_d    = '0;
      neg_d    = a_sel_c[W-1] ^ b_sel_c[W-1];
      ack_p_d  = 1'b0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST_PW) begin
    if (RST_PW) begin
      state_q      <= IDLE;
      armed_q      <= 1'b0;
      ack_i_q      <= 1'b0;
      ack_v_q      <= 1'b0;
      op_i_q       <= '0;
      op_v_q       <= '0;
      wait_i_q     <= 1'b0;
      pend_i_q     <= 1'b0;
      pend_v_q     <= 1'b0;
      pend_i_val_q <= '0;
      pend_v_val_q <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      neg_q        <= 1'b0;
      rise_q       <= 1'b0;
      ack_p_q      <= 1'b0;
      of_q         <= 1'b0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      ack_i_q      <= ack_i_d;
      ack_v_q      <= ack_v_d;
      op_i_q       <= op_i_d;
      op_v_q       <= op_v_d;
      wait_i_q     <= wait_i_d;
      pend_i_q     <= pend_i_d;
      pend_v_q     <= pend_v_d;
      pend_i_val_q <= pend_i_val_d;
      pend_v_val_q <= pend_v_val_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      neg_q        <= neg_d;
      rise_q       <= rise_d;
      ack_p_q      <= ack_p_d;
      of_q         <= of_d;
      res_q        <= res_d;
    end
  end

  assign ACK_P    = ack_p_q;
  assign O_F      = of_q;
  assign RESULT_P = res_q;

endmodule

// File: tb/tb_iv_power_multiplier.sv
// Self-checking bench for iv_power_multiplier with a queue-based scoreboard.
module tb_iv_power_multiplier;

  localparam int unsigned W    = 32;
  localparam int unsigned FRAC = 26;
`ifdef POWER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic         of;
    logic [W-1:0] res;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST_PW;
  logic         ACK_I, ACK_V;
  logic [W-1:0] RESULT_I, RESULT_V;
  logic         ACK_P, O_F;
  logic [W-1:0] RESULT_P;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  iv_power_multiplier #(.W(W), .FRAC(FRAC)) dut (
    .CLK      (CLK),
    .RST_PW   (RST_PW),
    .ACK_I    (ACK_I),
    .RESULT_I (RESULT_I),
    .ACK_V    (ACK_V),
    .RESULT_V (RESULT_V),
    .ACK_P    (ACK_P),
    .O_F      (O_F),
    .RESULT_P (RESULT_P)
  );

  always #5 CLK = ~CLK;

  // Reference: full signed 64-bit product, magnitude truncated by FRAC, then signed.
  function automatic exp_t model(input logic [W-1:0] i, input logic [W-1:0] v);
    longint p, mag;
    bit     neg;
    exp_t   e;
    p    = longint'($signed(i)) * longint'($signed(v));
    neg  = (p < 0);
    mag  = neg ? -p : p;
    mag  = mag >> FRAC;
    e.of = (mag >= 64'sd2147483648) && !(neg && (mag == 64'sd2147483648));
    if (e.of && SAT) e.res = neg ? 32'h80000000 : 32'h7FFFFFFF;
    else             e.res = neg ? W'(-mag) : W'(mag);
    return e;
  endfunction

  // Waits (bounded) for ACK_P to reach lvl, sampling 1 time unit after each rising edge.
  task automatic wait_ack(input logic lvl, input int budget, output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < budget) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (ACK_P === lvl) got = 1'b1;
    end
  endtask

  task automatic drop_both();
    @(negedge CLK);
    ACK_I = 1'b0;
    ACK_V = 1'b0;
  endtask

  task automatic raise_both(input logic [W-1:0] i, input logic [W-1:0] v);
    @(negedge CLK);
    RESULT_I = i;
    RESULT_V = v;
    ACK_I    = 1'b1;
    ACK_V    = 1'b1;
  endtask

  task automatic test_reset();
    RST_PW = 1'b1; ACK_I = 1'b0; ACK_V = 1'b0; RESULT_I = '0; RESULT_V = '0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++; if (ACK_P !== 1'b0) $display("FAIL reset ACK_P: got %b want 0", ACK_P); else n_pass++;
    n_checks++; if (O_F !== 1'b0) $display("FAIL reset O_F: got %b want 0", O_F); else n_pass++;
    n_checks++; if (RESULT_P !== '0) $display("FAIL reset RESULT_P: got %h want 0", RESULT_P); else n_pass++;
    @(negedge CLK);
    RST_PW = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_basic_latency();
    exp_t e;
    @(negedge CLK);
    RESULT_I = 32'h04000000; ACK_I = 1'b1;
    repeat (3) @(negedge CLK);
    RESULT_V = 32'h08000000; ACK_V = 1'b1;
    exp_q.push_back(model(32'h04000000, 32'h08000000));
    @(posedge CLK);
    repeat (W + 1) @(posedge CLK);
    #1;
    n_checks++; if (ACK_P !== 1'b0) $display("FAIL basic ACK_P early at k+W+1: got %b want 0", ACK_P); else n_pass++;
    @(posedge CLK);
    #1;
    n_checks++; if (ACK_P !== 1'b1) $display("FAIL basic ACK_P at k+W+2: got %b want 1", ACK_P); else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if ({O_F, RESULT_P} !== {e.of, e.res})
      $display("FAIL basic result: got of=%b res=%h want of=%b res=%h", O_F, RESULT_P, e.of, e.res);
    else n_pass++;
    n_checks++; if (RESULT_P !== 32'h08000000) $display("FAIL basic constant: got %h want 08000000", RESULT_P); else n_pass++;
  endtask

  task automatic test_patterns();
    logic [W-1:0] ti[8];
    logic [W-1:0] tv[8];
    exp_t e;
    bit   got;
    int   cyc;
    ti = '{32'hFC000000, 32'h40000000, 32'hF8000000, 32'h08000000,
           32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
    tv = '{32'h02000000, 32'h40000000, 32'h40000000, 32'h40000000,
           32'hFC000000, 32'h04000001, 32'h04000000, 32'hFC000000};
    for (int k = 0; k < 8; k++) begin
      drop_both();
      raise_both(ti[k], tv[k]);
      exp_q.push_back(model(ti[k], tv[k]));
      @(posedge CLK);
      #1;
      n_checks++; if (ACK_P !== 1'b0) $display("FAIL pattern[%0d] ACK_P drop on MULT entry: got %b want 0", k, ACK_P); else n_pass++;
      wait_ack(1'b1, W + 10, got, cyc);
      n_checks++; if (!got || cyc != W + 2) $display("FAIL pattern[%0d] latency: got %0d cycles (seen=%b) want %0d", k, cyc, got, W + 2); else n_pass++;
      e = exp_q.pop_front();
      n_checks++;
      if ({O_F, RESULT_P} !== {e.of, e.res})
        $display("FAIL pattern[%0d] result: got of=%b res=%h want of=%b res=%h", k, O_F, RESULT_P, e.of, e.res);
      else n_pass++;
    end
  endtask

  task automatic test_wait_overwrite();
    exp_t e;
    bit   got;
    int   cyc;
    drop_both();
    @(negedge CLK);
    RESULT_I = 32'h04000000; ACK_I = 1'b1;
    @(posedge CLK);
    #1;
    n_checks++; if (ACK_P !== 1'b1) $display("FAIL overwrite ACK_P held in WAIT: got %b want 1", ACK_P); else n_pass++;
    @(negedge CLK);
    ACK_I = 1'b0;
    @(negedge CLK);
    RESULT_I = 32'h0C000000; ACK_I = 1'b1;
    @(negedge CLK);
    RESULT_V = 32'h04000000; ACK_V = 1'b1;
    exp_q.push_back(model(32'h0C000000, 32'h04000000));
    wait_ack(1'b0, 5, got, cyc);
    n_checks++; if (!got) $display("FAIL overwrite ACK_P drop: got %b want 0", ACK_P); else n_pass++;
    wait_ack(1'b1, W + 10, got, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || {O_F, RESULT_P} !== {e.of, e.res})
      $display("FAIL overwrite result: got ack=%b of=%b res=%h want of=%b res=%h", got, O_F, RESULT_P, e.of, e.res);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   got;
    int   cyc;
    drop_both();
    raise_both(32'h0A000000, 32'h04000000);
    exp_q.push_back(model(32'h0A000000, 32'h04000000));
    @(posedge CLK);
    repeat (3) @(negedge CLK);
    ACK_I = 1'b0; ACK_V = 1'b0;
    @(negedge CLK);
    RESULT_I = 32'h7C000000; ACK_I = 1'b1;
    @(negedge CLK);
    ACK_I = 1'b0;
    @(negedge CLK);
    RESULT_I = 32'h06000000; ACK_I = 1'b1;
    RESULT_V = 32'hF0000000; ACK_V = 1'b1;
    exp_q.push_back(model(32'h06000000, 32'hF0000000));
    @(negedge CLK);
    RESULT_I = 32'h12345678; RESULT_V = 32'h9ABCDEF0;
    wait_ack(1'b1, 2 * W, got, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || {O_F, RESULT_P} !== {e.of, e.res})
      $display("FAIL b2b first result: got ack=%b of=%b res=%h want of=%b res=%h", got, O_F, RESULT_P, e.of, e.res);
    else n_pass++;
    wait_ack(1'b0, 10, got, cyc);
    n_checks++; if (!got) $display("FAIL b2b ACK_P drop on second MULT entry: got %b want 0", ACK_P); else n_pass++;
    wait_ack(1'b1, 2 * W, got, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || {O_F, RESULT_P} !== {e.of, e.res})
      $display("FAIL b2b second result: got ack=%b of=%b res=%h want of=%b res=%h", got, O_F, RESULT_P, e.of, e.res);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mult();
    exp_t e;
    bit   got;
    int   cyc;
    drop_both();
    raise_both(32'h0C000000, 32'h0C000000);
    @(posedge CLK);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    RST_PW = 1'b1;
    #1;
    n_checks++;
    if ({ACK_P, O_F, RESULT_P} !== '0)
      $display("FAIL midreset outputs: got ack=%b of=%b res=%h want all 0", ACK_P, O_F, RESULT_P);
    else n_pass++;
    @(negedge CLK);
    RST_PW = 1'b0;
    wait_ack(1'b1, 3 * W, got, cyc);
    n_checks++; if (got) $display("FAIL midreset spurious ACK_P: got 1 after %0d cycles want 0", cyc); else n_pass++;
    drop_both();
    raise_both(32'hFE000000, 32'h0C000000);
    exp_q.push_back(model(32'hFE000000, 32'h0C000000));
    wait_ack(1'b1, W + 10, got, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || {O_F, RESULT_P} !== {e.of, e.res})
      $display("FAIL midreset fresh result: got ack=%b of=%b res=%h want of=%b res=%h", got, O_F, RESULT_P, e.of, e.res);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_patterns();
    test_wait_overwrite();
    test_back_to_back();
    test_reset_mid_mult();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
